// File: rtl/alu_pkg.sv
// Shared ALU control codes, legal-code helpers and the response-register state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b1001;
    localparam logic [3:0] ALU_NAND = 4'b1100;
    localparam logic [3:0] ALU_XOR  = 4'b1101;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic        v;
        logic        n;
        logic        z;
        logic        err;
    } resp_t;

    function automatic logic is_legal_code(input logic [3:0] code);
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
            ALU_NOR, ALU_NAND, ALU_XOR: is_legal_code = 1'b1;
            default:                    is_legal_code = 1'b0;
        endcase
    endfunction

    function automatic logic is_arith_code(input logic [3:0] code);
        is_arith_code = (code == ALU_ADD) || (code == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu32.sv
// 32-bit combinational ALU with overflow, negative and zero flags.
module alu32
    import alu_pkg::*;
(
    output logic [31:0] result,
    output logic        v_flag,
    output logic        n_flag,
    output logic        z_flag,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [3:0]  alu_control_code
);

    always_comb begin
        result = '0;
        v_flag = 1'b0;
        case (alu_control_code)
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_NOR:  result = ~(op1 | op2);
            ALU_NAND: result = ~(op1 & op2);
            ALU_XOR:  result = op1 ^ op2;
            ALU_ADD: begin
                result = op1 + op2;
                v_flag = (op1[31] == op2[31]) && (result[31] != op1[31]);
            end
            ALU_SUB: begin
                result = op1 - op2;
                v_flag = (op1[31] != op2[31]) && (result[31] != op1[31]);
            end
            default: result = '0;
        endcase
        n_flag = result[31];
        z_flag = (result == 32'd0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a shared ALU with a single registered response slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [31:0]      req0_op1,
    input  logic [31:0]      req0_op2,
    input  logic [31:0]      req1_op1,
    input  logic [31:0]      req1_op2,
    input  logic [3:0]       req0_code,
    input  logic [3:0]       req1_code,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_result,
    output logic             resp_v,
    output logic             resp_n,
    output logic             resp_z,
    output logic             resp_err,
    output logic [CNT_W-1:0] op_count
);

    state_t      state, next_state;
    logic        prio;
    resp_t       resp_q, resp_d;
    logic        can_accept, gnt0, gnt1, grant, sel;
    logic [31:0] alu_op1, alu_op2, alu_res;
    logic [3:0]  alu_code;
    logic        alu_v, alu_n, alu_z, legal;

    // A full slot can accept only when it is being drained on the same edge.
    always_comb begin
        can_accept = (state == EMPTY) || resp_ready;
        gnt0       = reset_n && can_accept && req0_valid && (!req1_valid || (prio == 1'b0));
        gnt1       = reset_n && can_accept && req1_valid && (!req0_valid || (prio == 1'b1));
        grant      = gnt0 || gnt1;
        sel        = gnt1;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign alu_op1  = sel ? req1_op1  : req0_op1;
    assign alu_op2  = sel ? req1_op2  : req0_op2;
    assign alu_code = sel ? req1_code : req0_code;

    alu32 u_alu (
        .result           (alu_res),
        .v_flag           (alu_v),
        .n_flag           (alu_n),
        .z_flag           (alu_z),
        .op1              (alu_op1),
        .op2              (alu_op2),
        .alu_control_code (alu_code)
    );

    // Illegal codes still answer, with every flag and the result cleared.
    always_comb begin
        legal         = is_legal_code(alu_code);
        resp_d        = '0;
        resp_d.id     = sel;
        resp_d.result = legal ? alu_res : 32'd0;
        resp_d.v      = legal && is_arith_code(alu_code) && alu_v;
        resp_d.n      = legal && alu_n;
        resp_d.z      = legal && alu_z;
        resp_d.err    = !legal;
    end

    always_comb begin
        next_state = state;
        if (grant)
            next_state = FULL;
        else if ((state == FULL) && resp_ready)
            next_state = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= EMPTY;
        else          state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio     <= 1'b0;
            resp_q   <= '0;
            op_count <= '0;
        end else begin
            if (grant) begin
                resp_q <= resp_d;
                prio   <= ~sel;
            end
            if ((state == FULL) && resp_ready)
                op_count <= op_count + 1'b1;
        end
    end

    assign resp_valid  = (state == FULL);
    assign resp_id     = resp_q.id;
    assign resp_result = resp_q.result;
    assign resp_v      = resp_q.v;
    assign resp_n      = resp_q.n;
    assign resp_z      = resp_q.z;
    assign resp_err    = resp_q.err;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be: CNT_W, 16, width of the completed-operation counter.
REQ-002 Reset SHALL be synchronous and active-low; there SHALL be one clock domain only.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  requester's operation accepted this cycle.
REQ-007 req0_op1, req0_op2, req1_op1, req1_op2  input  32  operands.
REQ-008 req0_code / req1_code  input  4  ALU control code.
REQ-009 resp_valid  output  1  response register holds a result.
REQ-010 resp_ready  input  1  consumer takes the response this cycle.
REQ-011 resp_id  output  1  requester index owning the response.
REQ-012 resp_result  output  32  ALU result.
REQ-013 resp_v, resp_n, resp_z  output  1 each  ALU overflow, negative and zero flags.
REQ-014 resp_err  output  1  illegal control code.
REQ-015 op_count  output  CNT_W  number of responses consumed.

Function
REQ-016 Legal codes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1001, NAND 1100, XOR 1101.
REQ-017 The block SHALL have two states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-018 can_accept SHALL be (state==EMPTY) or (state==FULL and resp_ready).
REQ-019 There SHALL be at most one grant per cycle, and only when can_accept is high.
REQ-020 Granting SHALL use round-robin order: prio pointer names the favoured requester; if only one requester is valid, that requester is granted.
REQ-021 After each grant, prio SHALL point to the requester that was not granted.
REQ-022 reqN_ready SHALL be combinational and SHALL equal the grant to requester N.
REQ-023 reqN_ready SHALL never be asserted while reqN_valid is low.
REQ-024 Operands and code of the granted requester SHALL drive the shared alu32 combinationally.
REQ-025 On a grant, the ALU result and flags SHALL be registered into the response on the same edge, giving a latency of 1 cycle from handshake to resp_valid.
REQ-026 For an illegal code, the block SHALL register resp_err=1 with resp_result=0 and resp_v=resp_n=resp_z=0, and SHALL still produce a response.
REQ-027 resp_v SHALL be forwarded from alu32 for ADD/SUB and forced to 0 for logic codes.
REQ-028 While FULL and resp_ready=0, all resp_* outputs SHALL hold stable and no grant SHALL occur.
REQ-029 When FULL with resp_ready=1 and a grant in the same cycle, the block SHALL stay FULL with the new response and no bubble.
REQ-030 When FULL with resp_ready=1 and no valid request, the block SHALL go to EMPTY.
REQ-031 op_count SHALL increment on each resp_valid&&resp_ready and SHALL wrap from all-ones to 0.

Reset
REQ-032 While reset_n is low at an edge, state SHALL be EMPTY and prio SHALL be 0.
REQ-033 While reset_n is low at an edge, resp_result, resp_id, resp_v, resp_n, resp_z, resp_err and op_count SHALL be 0.
REQ-034 reqN_ready SHALL be 0 while reset_n is low.
REQ-035 Reset asserted while FULL SHALL discard the held response without a handshake.

Structure
REQ-036 The ALU code constants, the legal-code check function and the EMPTY/FULL state encoding SHALL reside in a shared package, alu_pkg.
REQ-037 The block SHALL instantiate exactly one alu32 sub-module, with ports (result, v_flag, n_flag, z_flag, op1, op2, alu_control_code).

Verification
REQ-038 req0 only, AND 0x000000ff,0x00000f0f, resp_ready=1 -> next cycle resp_valid=1, id=0, result=0x0000000f, z=0, err=0.
REQ-039 Both valid for 4 cycles, ADD 10+10 on req0 and SUB 10-(-10) on req1, resp_ready=1 -> grants 0,1,0,1, every result 20, v=0, n=0.
REQ-040 SUB -10-(-10) on req1, resp_ready held low for 3 cycles -> result 0 with z=1 held stable, no new grant, req0_ready=0 throughout.
REQ-041 req0 code 0011 -> resp_err=1, result 0, flags 0, op_count increments on drain.
REQ-042 ADD 0x7fffffff+1 -> result 0x80000000, v=1, n=1.
REQ-043 reset_n low for one cycle while FULL -> resp_valid=0, op_count=0, prio=0 next cycle.
REQ-044 op_count at all-ones plus one drain -> op_count=0.
